mac_psum_quant: RTL and testbench
=================================

// Module: mac_psum_quant
// PURPOSE
//  Downstream stage of the N-lane mac. Accumulates NUM_TILE consecutive signed mac
//  results (acc_o/vld_o) into one output-pixel partial sum and adds a per-channel bias.
//  It then applies rounding right-shift, optional ReLU and saturation to WQ bits.
//  Feeds the activation write-back buffer.
// PARAMETERS
//  WI       8   mac operand width (matches mac)
//  N        16  mac lane count (matches mac)
//  WIN      2*(WI+1)+$clog2(N)  width of acc_i (= mac WO)
//  NUM_TILE 4   mac results per output group, >=1
//  WQ       8   quantized output width, signed
//  localparam WA = WIN+$clog2(NUM_TILE)+2  accumulator width, signed
// PORTS
//  clk      in   1     clock, all state on rising edge
//  rst      in   1     synchronous reset, active-high
//  vld_i    in   1     acc_i valid (connect mac vld_o)
//  acc_i    in   WIN   signed partial sum from mac
//  clr_i    in   1     abort current group, clears tile counter
//  bias_i   in   WIN   signed bias, sampled on first tile of a group
//  shift_i  in   5     right-shift amount, sampled on first tile
//  relu_i   in   1     ReLU enable, sampled on first tile
//  q_o      out  WQ    signed quantized result
//  vld_o    out  1     q_o valid, one-cycle pulse per group
//  sat_o    out  1     saturation occurred for this q_o (qualified by vld_o)
//  busy_o   out  1     group in progress (tile_cnt != 0)
// BEHAVIOUR
//  - Reset: q_o=0, vld_o=0, sat_o=0, busy_o=0, tile_cnt=0, accumulator=0, cfg regs=0.
//    Reset mid-group discards the group. No vld_o is produced for it.
//  - Stage 1 (accumulate), on vld_i & !clr_i:
//    - tile_cnt==0: acc <= sext(bias_i)+sext(acc_i); latch shift_i, relu_i.
//    - otherwise: acc <= acc+sext(acc_i).
//    - tile_cnt increments and wraps to 0 after NUM_TILE-1. On the wrap, done_q <= 1 for one cycle.
//    - NUM_TILE==1: every vld_i is a complete group.
//  - Stage 2 (quantize), when done_q:
//    - r = (shift==0) ? acc : (acc + (1<<(shift-1))) >>> shift  (arithmetic, round half up).
//    - If relu and r<0, then r=0.
//    - Saturate to [-2^(WQ-1), 2^(WQ-1)-1]. sat_o=1 iff clipping occurred (ReLU zeroing is not saturation).
//    - Register result into q_o. vld_o=1 for exactly one cycle.
//    - q_o holds its value until the next vld_o.
//  - Latency: last vld_i sampled at edge t -> vld_o/q_o valid after edge t+1.
//  - Throughput: back-to-back groups with no bubbles. A first tile of the next group at edge t+1 overwrites acc
//    while stage 2 reads the old value at the same edge.
//  - vld_i gaps inside a group are allowed. The counter holds while vld_i=0.
//  - clr_i: tile_cnt <= 0 and done_q <= 0. clr_i has priority over a simultaneous vld_i; that sample is dropped.
//    clr_i does not cancel a vld_o already registered.
//  - shift_i >= WA: r = 0 for acc >= 0 (before ReLU) and -1 for acc < 0.
//  - acc never overflows within WA for any NUM_TILE inputs plus bias. No wrap handling is required.
//  - busy_o = (tile_cnt != 0), registered.
// TESTING (defaults WI=8, N=16, NUM_TILE=4, WQ=8)
//  1. Four vld_i with acc_i=120 (mac act=0..15, w=1), bias=0, shift=0
//     -> acc=480; q_o=127, sat_o=1, vld_o one cycle after the 4th sample.
//  2. Same stream, shift=2, bias=8 -> (488+2)>>2=122; q_o=122, sat_o=0.
//     Rounding check: acc_i={1,2,3,0}, bias=0, shift=2 -> (6+2)>>2 = q_o=2.
//  3. acc_i=-120 x4, bias=0, shift=2 with relu=0 -> q_o=-120.
//     Same with relu=1 -> q_o=0, sat_o=0. With shift=0, relu=0 -> q_o=-128, sat_o=1.
//  4. Eight consecutive vld_i, groups A (acc_i=10, shift=0) and B (acc_i=20, shift=0)
//     -> vld_o pulses exactly 4 cycles apart with q_o=40 then 80.
//     Repeat with 2-cycle vld_i gaps inside group B -> same q_o values.
//  5. Two tiles, then clr_i together with a third vld_i, then 4 fresh tiles of 5
//     -> one vld_o, q_o=20, busy_o=0 after clr_i.
//  6. Two tiles, then rst for 2 cycles -> no vld_o, all outputs 0.
//     A following group of 4x1 -> q_o=4.

Source files
------------

// File: rtl/mac_psum_quant.sv
// Partial-sum accumulator behind the N-lane mac: sums NUM_TILE tiles plus bias,
// then applies a rounding shift, optional ReLU and saturation to a WQ-bit result.
module mac_psum_quant #(
   parameter int WI       = 8,
   parameter int N        = 16,
   parameter int WIN      = 2*(WI+1)+$clog2(N),
   parameter int NUM_TILE = 4,
   parameter int WQ       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_i,
   input  logic [WIN-1:0]        acc_i,
   input  logic                  clr_i,
   input  logic [WIN-1:0]        bias_i,
   input  logic [4:0]            shift_i,
   input  logic                  relu_i,
   output logic [WQ-1:0]         q_o,
   output logic                  vld_o,
   output logic                  sat_o,
   output logic                  busy_o
);

   localparam int WA = WIN + $clog2(NUM_TILE) + 2;
   localparam int CW = (NUM_TILE > 1) ? $clog2(NUM_TILE) : 1;
   localparam logic signed [WA:0] QMAX = (WA+1)'((64'd1 << (WQ-1)) - 64'd1);
   localparam logic signed [WA:0] QMIN = ~QMAX;

   logic [CW-1:0]        tile_cnt;
   logic [CW-1:0]        cnt_n;
   logic signed [WA-1:0] acc;
   logic [4:0]           shift_q;
   logic                 relu_q;
   logic                 done_q;
   logic [WA-1:0]        acc_ext;
   logic [WA-1:0]        bias_ext;
   logic                 first;
   logic                 last;

   assign acc_ext  = {{(WA-WIN){acc_i[WIN-1]}}, acc_i};
   assign bias_ext = {{(WA-WIN){bias_i[WIN-1]}}, bias_i};
   assign first    = (tile_cnt == '0);
   assign last     = (tile_cnt == CW'(NUM_TILE-1));

   always_comb begin
      cnt_n = tile_cnt;
      if (clr_i)
         cnt_n = '0;
      else if (vld_i)
         cnt_n = last ? '0 : tile_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tile_cnt <= '0;
         acc      <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         tile_cnt <= cnt_n;
         busy_o   <= (cnt_n != '0);
         done_q   <= !clr_i && vld_i && last;
         if (vld_i && !clr_i) begin
            if (first) begin
               acc     <= bias_ext + acc_ext;
               shift_q <= shift_i;
               relu_q  <= relu_i;
            end else begin
               acc <= acc + acc_ext;
            end
         end
      end
   end

   // One extra bit keeps the rounding add from overflowing before the shift.
   logic signed [WA:0] rnd;
   logic signed [WA:0] r;
   logic [WQ-1:0]      q_n;
   logic               sat_n;

   always_comb begin
      rnd = '0;
      if (shift_q == 5'd0)
         r = {acc[WA-1], acc};
      else if (int'(shift_q) >= WA)
         r = acc[WA-1] ? '1 : '0;
      else begin
         rnd = {acc[WA-1], acc} + ((WA+1)'(1) << (shift_q - 5'd1));
         r   = rnd >>> shift_q;
      end
      if (relu_q && r[WA])
         r = '0;
      sat_n = 1'b0;
      if (r > QMAX) begin
         r     = QMAX;
         sat_n = 1'b1;
      end else if (r < QMIN) begin
         r     = QMIN;
         sat_n = 1'b1;
      end
      q_n = r[WQ-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_o   <= '0;
         vld_o <= 1'b0;
         sat_o <= 1'b0;
      end else begin
         vld_o <= done_q;
         if (done_q) begin
            q_o   <= q_n;
            sat_o <= sat_n;
         end
      end
   end

endmodule

// File: tb/tb_mac_psum_quant.sv
// Bench for mac_psum_quant: directed cases with literal results plus random
// traffic checked cycle by cycle against a group-level arithmetic model.
module tb_mac_psum_quant;

   localparam int WI = 8, N = 16, WIN = 2*(WI+1)+$clog2(N), NT = 4, WQ = 8;
   localparam int WA = WIN + $clog2(NT) + 2;

   logic clk = 1'b0;
   logic rst, vld_i, clr_i, relu_i;
   logic [WIN-1:0] acc_i, bias_i;
   logic [4:0] shift_i;
   logic [WQ-1:0] q_o;
   logic vld_o, sat_o, busy_o;

   always #5 clk = ~clk;

   mac_psum_quant #(.WI(WI), .N(N), .WIN(WIN), .NUM_TILE(NT), .WQ(WQ)) dut (
      .clk(clk), .rst(rst), .vld_i(vld_i), .acc_i(acc_i), .clr_i(clr_i),
      .bias_i(bias_i), .shift_i(shift_i), .relu_i(relu_i),
      .q_o(q_o), .vld_o(vld_o), .sat_o(sat_o), .busy_o(busy_o));

   int n_chk = 0, n_fail = 0;
   int m_cnt = 0, m_shift = 0, cyc_no = 0, npulse = 0;
   longint m_acc = 0;
   bit m_relu = 0, pend = 0, ps = 0;
   int pq = 0;
   bit e_vld = 0, e_sat = 0, e_busy = 0;
   int e_q = 0;
   int last_q = 0;
   bit last_sat = 0;
   int pulse_cyc[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   function automatic void quant(input longint a, input int s, input bit r,
                                 output int q, output bit st);
      longint x;
      longint qmax = (longint'(1) << (WQ-1)) - 1;
      if (s == 0) x = a;
      else if (s >= WA) x = (a < 0) ? -1 : 0;
      else x = (a + (longint'(1) << (s-1))) >>> s;
      if (r && x < 0) x = 0;
      st = 0;
      if (x > qmax) begin x = qmax; st = 1; end
      else if (x < -qmax-1) begin x = -qmax-1; st = 1; end
      q = int'(x);
   endfunction

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic cyc(input bit v, input longint a = 0, input bit c = 0, input longint b = 0,
                      input int s = 0, input bit r = 0, input bit rs = 0);
      rst = rs; vld_i = v; acc_i = WIN'(a); clr_i = c; bias_i = WIN'(b);
      shift_i = 5'(s); relu_i = r;
      @(posedge clk);
      cyc_no++;
      if (rs) begin
         m_cnt = 0; m_acc = 0; m_shift = 0; m_relu = 0; pend = 0;
         e_vld = 0; e_q = 0; e_sat = 0;
      end else begin
         e_vld = pend;
         if (pend) begin e_q = pq; e_sat = ps; end
         pend = 0;
         if (c) m_cnt = 0;
         else if (v) begin
            if (m_cnt == 0) begin m_acc = b + a; m_shift = s; m_relu = r; end
            else m_acc += a;
            m_cnt++;
            if (m_cnt == NT) begin
               m_cnt = 0;
               pend = 1;
               quant(m_acc, m_shift, m_relu, pq, ps);
            end
         end
      end
      e_busy = (m_cnt != 0);
      #1;
      chk("vld_o", vld_o, e_vld);
      chk("busy_o", busy_o, e_busy);
      chk("q_o", longint'($signed(q_o)), e_q);
      if (e_vld || rs) chk("sat_o", sat_o, e_sat);
      if (vld_o) begin
         last_q = $signed(q_o); last_sat = sat_o; npulse++;
         pulse_cyc.push_back(cyc_no);
      end
   endtask

   task automatic group(input longint a, input longint b, input int s, input bit r);
      for (int i = 0; i < NT; i++) cyc(1, a, 0, b, s, r);
   endtask

   initial begin
      int q_tmp;
      bit s_tmp;
      longint rounding[4] = '{1, 2, 3, 0};

      // model pinned by hand-computed points
      quant(480, 0, 0, q_tmp, s_tmp);  chk("model_480", q_tmp, 127);
      quant(488, 2, 0, q_tmp, s_tmp);  chk("model_488", q_tmp, 122);
      quant(-5, 31, 0, q_tmp, s_tmp);  chk("model_bigshift", q_tmp, -1);

      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("reset_q", longint'($signed(q_o)), 0);
      chk("reset_vld", vld_o, 0);
      chk("reset_busy", busy_o, 0);

      group(120, 0, 0, 0); cyc(0);
      chk("t1_q", last_q, 127); chk("t1_sat", last_sat, 1);

      group(120, 8, 2, 0); cyc(0);
      chk("t2_q", last_q, 122); chk("t2_sat", last_sat, 0);
      for (int i = 0; i < NT; i++) cyc(1, rounding[i], 0, 0, 2, 0);
      cyc(0);
      chk("t2_round", last_q, 2);

      group(-120, 0, 2, 0); cyc(0); chk("t3_neg", last_q, -120);
      group(-120, 0, 2, 1); cyc(0); chk("t3_relu", last_q, 0); chk("t3_relu_sat", last_sat, 0);
      group(-120, 0, 0, 0); cyc(0); chk("t3_clip", last_q, -128); chk("t3_clip_sat", last_sat, 1);

      pulse_cyc.delete();
      group(10, 0, 0, 0); group(20, 0, 0, 0); cyc(0);
      chk("t4_pulses", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) chk("t4_spacing", pulse_cyc[1] - pulse_cyc[0], 4);
      chk("t4_q_b", last_q, 80);
      group(10, 0, 0, 0);
      for (int i = 0; i < NT; i++) begin cyc(1, 20); cyc(0); cyc(0); end
      chk("t4_gap_q", last_q, 80);

      npulse = 0;
      cyc(1, 5); cyc(1, 5); cyc(1, 5, 1);
      chk("t5_busy_clr", busy_o, 0);
      group(5, 0, 0, 0); cyc(0); cyc(0);
      chk("t5_pulses", npulse, 1); chk("t5_q", last_q, 20);

      npulse = 0;
      cyc(1, 7); cyc(1, 7);
      cyc(0, 0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 0, 1);
      chk("t6_q", longint'($signed(q_o)), 0); chk("t6_sat", sat_o, 0);
      chk("t6_busy", busy_o, 0);
      cyc(0); cyc(0);
      chk("t6_nopulse", npulse, 0);
      group(1, 0, 0, 0); cyc(0);
      chk("t6_q_after", last_q, 4);

      for (int i = 0; i < 3000; i++) begin
         longint a, b;
         int s;
         a = ($urandom_range(0, 3) == 0) ? longint'($signed(WIN'($urandom)))
                                         : longint'($urandom_range(0, 600)) - 300;
         b = longint'($urandom_range(0, 2000)) - 1000;
         s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
         cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 39) == 0, b, s,
             $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
      end
      cyc(0); cyc(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
